// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: per-pin two-flop synchronizer, counter debouncer,
// edge-event pulses and sticky pending flags with an OR-reduced interrupt.
module gpio_in_conditioner #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [WIDTH-1:0] pinIn,
  input  logic [WIDTH-1:0] riseEn,
  input  logic [WIDTH-1:0] fallEn,
  input  logic [WIDTH-1:0] evtClr,
  output logic [WIDTH-1:0] gpioIn,
  output logic [WIDTH-1:0] riseEvt,
  output logic [WIDTH-1:0] fallEvt,
  output logic [WIDTH-1:0] evtPending,
  output logic             irq
);

  localparam int unsigned CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] pend_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // Debounce: a mismatch must persist DEB_CYCLES edges before it is accepted
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else begin
        cnt_d[i]    = '0;
        stable_d[i] = sync2[i];
        rise_d[i]   = sync2[i];
        fall_d[i]   = ~sync2[i];
      end
    end
  end

  // Set has priority over clear; enables only gate new events
  always_comb begin
    pend_d = (rise_q & riseEn) | (fall_q & fallEn) | (pend_q & ~evtClr);
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      sync1    <= '0;
      sync2    <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      pend_q   <= '0;
    end else begin
      sync1    <= pinIn;
      sync2    <= sync1;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pend_q   <= pend_d;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign gpioIn     = stable_q;
  assign riseEvt    = rise_q;
  assign fallEvt    = fall_q;
  assign evtPending = pend_q;
  assign irq        = |pend_q;

endmodule

// File: doc/gpio_in_conditioner.md
GPIO_IN_CONDITIONER -- requirements
Module: gpio_in_conditioner

Interface
REQ-001 Parameter WIDTH, default 16: number of input pins; matches the GPIO slave's gpioIn width.
REQ-002 Parameter DEB_CYCLES, default 4: consecutive synchronized-sample cycles required to accept a level change; legal range 1..65535.
REQ-003 CLK_I  input  1: single clock, all flops on rising edge.
REQ-004 RST_I  input  1: asynchronous, active-low reset.
REQ-005 pinIn  input  WIDTH: raw asynchronous board pins.
REQ-006 riseEn  input  WIDTH: per-bit enable for rising-edge events.
REQ-007 fallEn  input  WIDTH: per-bit enable for falling-edge events.
REQ-008 evtClr  input  WIDTH: per-bit clear for evtPending, level-sampled each cycle.
REQ-009 gpioIn  output  WIDTH: debounced stable levels; drives the GPIO slave's gpioIn.
REQ-010 riseEvt  output  WIDTH: one-cycle pulse per bit on an accepted 0->1 change.
REQ-011 fallEvt  output  WIDTH: one-cycle pulse per bit on an accepted 1->0 change.
REQ-012 evtPending  output  WIDTH: sticky per-bit event flags.
REQ-013 irq  output  1: OR-reduction of evtPending.

Function
REQ-014 Each bit SHALL pass through a two-flop synchronizer (sync1 <- pinIn, sync2 <- sync1); only sync2 is used downstream.
REQ-015 Each bit SHALL own an independent counter of ceil(log2(DEB_CYCLES))+1 bits, plus a stable register whose value is driven on gpioIn.
REQ-016 Per bit, per edge: if sync2 == stable, counter <- 0.
REQ-017 Per bit, per edge: if sync2 != stable and counter < DEB_CYCLES-1, counter <- counter+1.
REQ-018 Per bit, per edge: if sync2 != stable and counter == DEB_CYCLES-1, stable <- sync2 and counter <- 0.
REQ-019 Latency: a pin level held steady SHALL appear on gpioIn exactly DEB_CYCLES+2 rising edges after the first edge that samples it into sync1.
REQ-020 A sync2 excursion lasting fewer than DEB_CYCLES cycles SHALL NOT change gpioIn and SHALL leave the counter at 0 once sync2 returns.
REQ-021 With DEB_CYCLES = 1, stable SHALL update on the first mismatching edge, giving a latency of 3 edges.
REQ-022 riseEvt[i] SHALL be 1 for exactly the one cycle in which gpioIn[i] first shows 1 after a 0; fallEvt[i] behaves symmetrically; otherwise both are 0.
REQ-023 evtPending[i] SHALL set on an edge where (riseEvt[i] & riseEn[i]) | (fallEvt[i] & fallEn[i]) holds.
REQ-024 evtPending[i] SHALL clear on an edge where evtClr[i] = 1 and no set condition holds.
REQ-025 If set and clear coincide on one edge, set SHALL win.
REQ-026 Clearing enables SHALL NOT clear an already-pending flag.
REQ-027 irq SHALL be the combinational OR of the evtPending register bits, with no extra latency.
REQ-028 Bits are fully independent; simultaneous changes on multiple bits SHALL each complete on their own schedule.
REQ-029 The counter SHALL never exceed DEB_CYCLES-1.

Reset
REQ-030 While RST_I = 0, all outputs SHALL read 0 immediately (asynchronously): sync1, sync2, stable/gpioIn, counters, riseEvt, fallEvt, evtPending and irq.
REQ-031 Reset asserted mid-debounce SHALL discard the partial count.
REQ-032 After reset release with a pin held high, gpioIn SHALL rise after DEB_CYCLES+2 edges and SHALL emit riseEvt; this start-up event is intended behaviour.
REQ-033 Reset deassertion SHALL be taken synchronously to CLK_I through the same edge as the first functional sample.

Verification
REQ-034 DEB_CYCLES=4, pinIn[0] goes 0->1 and stays -> gpioIn[0]=1 on the 6th edge; riseEvt[0]=1 for exactly that one cycle; gpioIn=16'h0001.
REQ-035 DEB_CYCLES=4, pinIn[3] held high for 3 cycles, then low -> gpioIn stays 16'h0000; no riseEvt; counter[3] returns to 0.
REQ-036 riseEn=16'h0001, fallEn=0, pin 0 toggles 0->1->0 with stable gaps -> evtPending=16'h0001 and irq=1 after the rise; no change on the fall; evtClr[0] pulse -> evtPending=0, irq=0.
REQ-037 evtClr[0]=1 held across the edge where riseEvt[0]=1 with riseEn[0]=1 -> evtPending[0]=1 afterwards (set wins).
REQ-038 RST_I driven low 2 cycles into a debounce of pin 5, then released with the pin still high -> gpioIn[5]=0 during reset; after release gpioIn[5]=1 exactly DEB_CYCLES+2 edges later, with no earlier rise.
REQ-039 pinIn=16'hFFFF toggled together from all-zero -> all 16 gpioIn bits rise on the same edge; riseEvt=16'hFFFF for one cycle.
